edge_detect_multi: RTL
======================

# edge_detect_multi

Parametrised multi-channel edge detector: next generation of the single-byte any-edge detector. Each of `WIDTH` channels gets an optional input synchroniser and a debounce filter. Rising and falling edges are detected and enabled separately. Every detected event also sets a sticky status bit with write-1-to-clear, an overflow flag and a maskable interrupt. The block sits between raw level inputs (pins or cross-domain flags) and a register/interrupt front end.

## Interface
Parameters:
- `WIDTH`, 8: number of independent channels.
- `SYNC_STAGES`, 2: synchroniser flops per channel. 0 means `in` is sampled directly.
- `FILTER_LEN`, 1: consecutive cycles a new level must hold before it is accepted. Legal range 1..255. 1 means no filtering.

Ports:
- `clk`, input, 1: single clock; all state is updated on its rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `in`, input, `WIDTH`: raw channel levels.
- `rise_en`, input, `WIDTH`: enables rising-edge reporting per channel.
- `fall_en`, input, `WIDTH`: enables falling-edge reporting per channel.
- `clr`, input, `WIDTH`: write-1-to-clear for `sticky` and `ovf`. Sampled every cycle.
- `irq_mask`, input, `WIDTH`: 1 lets a channel's sticky bit drive `irq`.
- `rise`, output, `WIDTH`: one-cycle pulse on an accepted 0->1 transition, gated by `rise_en`.
- `fall`, output, `WIDTH`: one-cycle pulse on an accepted 1->0 transition, gated by `fall_en`.
- `anyedge`, output, `WIDTH`: `rise | fall`.
- `sticky`, output, `WIDTH`: latched event status.
- `ovf`, output, `WIDTH`: an event occurred while `sticky` was already set.
- `irq`, output, 1: `|(sticky & irq_mask)`, combinational from registered state.

## Operation
- **Synchroniser.** `s[i]` is `in[i]` delayed through `SYNC_STAGES` flops. All flops reset to 0.
- **Filter state.** Per channel:
  - Accepted level `lvl[i]`, reset 0.
  - Counter `cnt[i]`, width `$clog2(FILTER_LEN+1)`, minimum 1 bit, reset 0.
- **Filter rule, each cycle:**
  - If `s[i] == lvl[i]`, then `cnt[i] <= 0`.
  - Otherwise, if `cnt[i] == FILTER_LEN-1`, then `lvl[i] <= s[i]`, `cnt[i] <= 0`, and `upd[i]` = 1 this cycle.
  - Otherwise, `cnt[i] <= cnt[i]+1`.
  - A single cycle back at `lvl` restarts the count (glitch rejection).
- **Edge outputs.** `rise[i] <= upd[i] & s[i] & rise_en[i]` and `fall[i] <= upd[i] & ~s[i] & fall_en[i]`. Both are registered, in the same clock edge that updates `lvl`.
- **Disabled edges.** A disabled edge still updates `lvl`. It produces no pulse and no sticky/ovf effect.
- **Sticky and overflow.** Let `ev[i]` = next-cycle value of `anyedge[i]`.
  - `sticky[i] <= ev[i] | (sticky[i] & ~clr[i])`. Set wins over a simultaneous clear.
  - `ovf[i] <= (ev[i] & sticky[i] & ~clr[i]) | (ovf[i] & ~clr[i])`.
  - An event coinciding with `clr` sets `sticky` and does not set `ovf`.
- **Independence.** Channels are fully independent; no cross-channel state.
- **Reset.** All outputs and state go to 0 immediately on `rst_n` low, including mid-filter. After release, an input held at 1 is reported as a rising edge once it passes sync+filter.

## Timing
- **Latency.** An `in` change sampled at edge k (first synchroniser flop, or `s` when `SYNC_STAGES` = 0) produces `rise`/`fall` high from edge `k + SYNC_STAGES + FILTER_LEN - 1`, for exactly one cycle.
- **Sticky and ovf** update at the same edge as the pulse.
- **irq** follows `sticky` with zero additional delay.
- **Back-to-back edges.** With `SYNC_STAGES`=0 and `FILTER_LEN`=1, a toggle every cycle gives a pulse every cycle, with alternating `rise`/`fall`.
- **Legacy equivalence.** `SYNC_STAGES`=0, `FILTER_LEN`=1, all enables 1 is cycle-identical on `anyedge` to the legacy detector (edge reported at the edge after the change; prior value 0 out of reset).
- **Enable timing.** `rise_en`/`fall_en` are sampled in the cycle `upd` occurs. Changing them never creates or cancels a pending filter count.

## Test plan
- **Legacy mode.** `WIDTH`=8, `SYNC_STAGES`=0, `FILTER_LEN`=1, enables 0xFF. Drive `in` 0x00 -> 0x0F -> 0x0F -> 0xF0. Required `anyedge`: 0x0F, then 0x00, then 0xFF, each one cycle after the change. `rise`=0x0F on the first edge; on the third, `fall`=0x0F and `rise`=0xF0.
- **Sync latency.** `SYNC_STAGES`=2, `FILTER_LEN`=1. Raise `in[3]` at cycle 10 → `rise[3]` high only in cycle 12.
- **Debounce.** `FILTER_LEN`=4, `SYNC_STAGES`=0.
  - `in[0]` high for 3 cycles, low for 1, then high for 4 → exactly one `rise[0]`, in the 4th cycle of the final run.
  - A 3-cycle pulse alone gives no event.
- **Edge enables.** `rise_en`=0x01, `fall_en`=0x00. Toggle `in[0]` 1→0→1 → only `rise[0]` pulses, and `sticky`=0x01 after the first rise.
- **Sticky, ovf and irq.**
  - Two rises on channel 2 without clear → `sticky[2]`=1, `ovf[2]`=1.
  - `irq`=1 only when `irq_mask[2]`=1.
  - `clr[2]` coincident with a third event → `sticky[2]`=1, `ovf[2]`=0.
  - `clr[2]` alone → both 0 and `irq`=0.
- **Reset mid-operation.** Assert `rst_n`=0 with `FILTER_LEN`=4 and a count at 2 → all outputs 0 immediately. Release with `in`=0xFF → `rise`=0xFF after `SYNC_STAGES+3` cycles.

Source files
------------

// File: rtl/edge_detect_multi_if.sv
// Bus bundle for edge_detect_multi: channel levels, enables, clear and mask in;
// edge pulses, status and interrupt out.
interface edge_detect_multi_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] anyedge;
  logic [WIDTH-1:0] sticky;
  logic [WIDTH-1:0] ovf;
  logic             irq;

  modport master (
    output in, rise_en, fall_en, clr, irq_mask,
    input  rise, fall, anyedge, sticky, ovf, irq
  );

  modport slave (
    input  in, rise_en, fall_en, clr, irq_mask,
    output rise, fall, anyedge, sticky, ovf, irq
  );
endinterface

// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: optional synchroniser, debounce filter, enabled
// rise/fall pulses, sticky write-1-to-clear status with overflow and masked irq.
module edge_detect_multi #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 1
) (
  input logic                clk,
  input logic                rst_n,
  edge_detect_multi_if.slave bus
);
  localparam int CNT_W = ($clog2(FILTER_LEN + 1) < 1) ? 1 : $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0]            s;
  logic [WIDTH-1:0]            lvl_q, lvl_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]            upd;
  logic [WIDTH-1:0]            rise_q, rise_d;
  logic [WIDTH-1:0]            fall_q, fall_d;
  logic [WIDTH-1:0]            sticky_q, sticky_d;
  logic [WIDTH-1:0]            ovf_q, ovf_d;
  logic [WIDTH-1:0]            ev;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = bus.in;
    end else begin : g_sync
      logic [WIDTH-1:0] sync_q [SYNC_STAGES];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
          sync_q[0] <= bus.in;
          for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // A new level is accepted only after FILTER_LEN consecutive differing samples;
  // any sample back at the accepted level restarts the count.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    upd   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i] != lvl_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          lvl_d[i] = s[i];
          upd[i]   = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  assign rise_d   = upd & s & bus.rise_en;
  assign fall_d   = upd & ~s & bus.fall_en;
  assign ev       = rise_d | fall_d;
  assign sticky_d = ev | (sticky_q & ~bus.clr);
  assign ovf_d    = (ev & sticky_q & ~bus.clr) | (ovf_q & ~bus.clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q    <= '0;
      cnt_q    <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      sticky_q <= '0;
      ovf_q    <= '0;
    end else begin
      lvl_q    <= lvl_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.rise    = rise_q;
  assign bus.fall    = fall_q;
  assign bus.anyedge = rise_q | fall_q;
  assign bus.sticky  = sticky_q;
  assign bus.ovf     = ovf_q;
  assign bus.irq     = |(sticky_q & bus.irq_mask);
endmodule
